// File: rtl/ama_riscv_mem_arb.sv
// ama_riscv_mem_arb: shares one main-memory port between icache reads and dcache reads/writes, one transaction at a time.
module ama_riscv_mem_arb #(
  parameter int AW = 32,
  parameter int DW = 128,
  parameter int STARVE_LIM = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          imem_req_valid,
  output logic          imem_req_ready,
  input  logic [AW-1:0] imem_req_addr,
  output logic          imem_rsp_valid,
  input  logic          imem_rsp_ready,
  output logic [DW-1:0] imem_rsp_data,
  input  logic          dmem_r_req_valid,
  output logic          dmem_r_req_ready,
  input  logic [AW-1:0] dmem_r_req_addr,
  input  logic          dmem_w_req_valid,
  output logic          dmem_w_req_ready,
  input  logic [AW-1:0] dmem_w_req_addr,
  input  logic [DW-1:0] dmem_w_req_data,
  output logic          dmem_rsp_valid,
  input  logic          dmem_rsp_ready,
  output logic [DW-1:0] dmem_rsp_data,
  output logic          mem_req_valid,
  input  logic          mem_req_ready,
  output logic          mem_req_we,
  output logic [AW-1:0] mem_req_addr,
  output logic [DW-1:0] mem_req_wdata,
  input  logic          mem_rsp_valid,
  output logic          mem_rsp_ready,
  input  logic [DW-1:0] mem_rsp_data
);
  localparam int CW = $clog2(STARVE_LIM + 1);
  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP, RSP} state_t;
  typedef enum logic [1:0] {G_NONE, G_IMEM, G_DMEM_R, G_DMEM_W} grant_t;
  state_t state_q, state_d;
  grant_t grant_q, grant_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d, rsp_data_q, rsp_data_d;
  logic we_q, we_d;
  logic idle, force_i, win_i, win_r, win_w, take, rsp_take;
  always_comb begin
    idle = state_q == IDLE && !rst;
    force_i = imem_req_valid && starve_cnt_q == CW'(STARVE_LIM);
    win_w = dmem_w_req_valid && !force_i;
    win_r = dmem_r_req_valid && !dmem_w_req_valid && !force_i;
    win_i = imem_req_valid && (force_i || !(dmem_w_req_valid || dmem_r_req_valid));
    imem_req_ready = idle && win_i;
    dmem_r_req_ready = idle && win_r;
    dmem_w_req_ready = idle && win_w;
    take = idle && (win_i || win_r || win_w);
    rsp_take = grant_q == G_IMEM ? imem_rsp_ready : dmem_rsp_ready;
    state_d = state_q;
    grant_d = grant_q;
    starve_cnt_d = starve_cnt_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    we_d = we_q;
    rsp_data_d = rsp_data_q;
    if (take) begin
      state_d = REQ;
      grant_d = win_i ? G_IMEM : win_w ? G_DMEM_W : G_DMEM_R;
      addr_d = win_i ? imem_req_addr : win_w ? dmem_w_req_addr : dmem_r_req_addr;
      wdata_d = win_w ? dmem_w_req_data : wdata_q;
      we_d = win_w;
      // Only dmem wins that bypass a waiting fetch count toward forcing imem
      starve_cnt_d = (!win_i && imem_req_valid) ?
        (starve_cnt_q == CW'(STARVE_LIM) ? starve_cnt_q : starve_cnt_q + CW'(1)) : '0;
    end
    if (state_q == REQ && mem_req_ready) begin
      state_d = we_q ? IDLE : WAIT_RSP;
      grant_d = we_q ? G_NONE : grant_q;
    end
    if (state_q == WAIT_RSP && mem_rsp_valid) begin
      state_d = RSP;
      rsp_data_d = mem_rsp_data;
    end
    if (state_q == RSP && rsp_take) begin
      state_d = IDLE;
      grant_d = G_NONE;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      grant_q <= G_NONE;
      starve_cnt_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      we_q <= 1'b0;
      rsp_data_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      starve_cnt_q <= starve_cnt_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      we_q <= we_d;
      rsp_data_q <= rsp_data_d;
    end
  end
  assign mem_req_valid = state_q == REQ;
  assign mem_req_we = we_q;
  assign mem_req_addr = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_rsp_ready = state_q == WAIT_RSP && !rst;
  assign imem_rsp_valid = state_q == RSP && grant_q == G_IMEM;
  assign dmem_rsp_valid = state_q == RSP && grant_q == G_DMEM_R;
  assign imem_rsp_data = rsp_data_q;
  assign dmem_rsp_data = rsp_data_q;
endmodule

// File: doc/ama_riscv_mem_arb.md
Name: ama_riscv_mem_arb

Overview:
- Arbiter and sequencer for the single main-memory port shared by the icache read channel and the dcache read and write channels.
- Sits between the caches and the main memory model; the memory then exposes one request channel and one response channel.
- One transaction in flight at a time.
- Read responses are routed back to the requester that issued them.
- Fixed priority, with a starvation guard for instruction fetch.

Parameters:
- AW, 32, address width (matches MEM_ADDR_BUS).
- DW, 128, data/line width (matches MEM_DATA_BUS).
- STARVE_LIM, 4, consecutive dmem grants allowed while an imem request waits before imem is forced.

Ports:
- clk in 1: clock, single domain.
- rst in 1: synchronous reset, active-high.
- imem_req_valid/imem_req_ready in/out 1: icache read request handshake.
- imem_req_addr in AW: icache line address.
- imem_rsp_valid/imem_rsp_ready out/in 1: icache read response handshake.
- imem_rsp_data out DW: icache read data.
- dmem_r_req_valid/dmem_r_req_ready in/out 1: dcache read request handshake.
- dmem_r_req_addr in AW: dcache read address.
- dmem_w_req_valid/dmem_w_req_ready in/out 1: dcache write request handshake.
- dmem_w_req_addr in AW: dcache write address.
- dmem_w_req_data in DW: dcache write data.
- dmem_rsp_valid/dmem_rsp_ready out/in 1: dcache read response handshake.
- dmem_rsp_data out DW: dcache read data.
- mem_req_valid/mem_req_ready out/in 1: main-memory request handshake.
- mem_req_we out 1: 1 = write, 0 = read.
- mem_req_addr out AW: main-memory address.
- mem_req_wdata out DW: main-memory write data.
- mem_rsp_valid/mem_rsp_ready in/out 1: main-memory read response handshake.
- mem_rsp_data in DW: main-memory read data.

Behaviour:
- Handshakes: a transfer occurs when valid and ready are both high on a rising clk.
  - Valid, once raised by this block, holds with stable payload until the transfer.
- Reset (rst=1 at a clk edge):
  - state=IDLE, starve_cnt=0, grant=NONE.
  - All *_ready and *_valid outputs 0; mem_req_we=0.
  - mem_req_addr, mem_req_wdata and the *_rsp_data outputs reset to 0.
  - Reset mid-transaction abandons the transaction; no response is delivered afterwards.
- States:
  - IDLE:
    - Upstream ready is combinational, asserted only for the winner among valid requesters.
    - Default priority: dmem_w > dmem_r > imem.
    - If imem_req_valid and starve_cnt==STARVE_LIM, imem wins instead.
    - On the winner's transfer: latch addr, data and we, record grant, go to REQ.
    - No valid requesters: stay in IDLE with all readies 0.
  - REQ:
    - mem_req_valid=1 with latched payload.
    - On mem_req transfer: write returns to IDLE; read goes to WAIT_RSP.
  - WAIT_RSP:
    - mem_rsp_ready=1.
    - On transfer: latch mem_rsp_data, go to RSP.
  - RSP:
    - Drive rsp_valid and data toward the grantee (imem_rsp_* or dmem_rsp_*).
    - On the grantee's rsp transfer: go to IDLE.
- mem_rsp_ready is 0 outside WAIT_RSP; stray responses are not consumed.
- starve_cnt, updated on each IDLE grant:
  - dmem grant while imem_req_valid=1: increment, saturating at STARVE_LIM.
  - imem grant, or any grant while imem_req_valid=0: clear to 0.
- Latency with zero-wait memory and ready consumers:
  - Upstream accept at cycle 0.
  - mem_req_valid at cycle 1.
  - mem_rsp accepted at cycle 2 at the earliest.
  - Upstream rsp_valid at cycle 3.
  - Write occupancy is 2 cycles.
- Back-pressure: requests arriving while state is not IDLE see ready=0 and must hold their valid.
- Simultaneous dmem_r and dmem_w: the write wins, so dirty-line write-back precedes refill.
- No combinational path from mem_* inputs to upstream outputs; response data is registered.

Test Plan:
- Single imem read at addr 0x40, mem returns 0xA5A5...A5 one cycle after its request accept -> imem_rsp_valid at cycle 3 with that data; dmem_rsp_valid stays 0.
- dmem_w (addr 0x100, data 0x1111...) and dmem_r (addr 0x200) asserted in the same cycle -> mem sees the write (we=1, 0x100) first, then the read (we=0, 0x200); read data is returned on dmem_rsp only.
- imem held valid while dmem_r is re-issued continuously, STARVE_LIM=4 -> exactly 4 dmem grants, then an imem grant; starve_cnt returns to 0.
- mem_req_ready held 0 for 5 cycles during a read -> mem_req_valid, addr and we stay stable; all upstream readies stay 0; the transaction completes once ready rises.
- dmem_rsp_ready held 0 for 3 cycles in RSP -> dmem_rsp_valid and data held; an imem request is not accepted until the response transfer.
- rst asserted in WAIT_RSP, then mem_rsp_valid pulses -> the response is not consumed (mem_rsp_ready=0), no upstream rsp_valid, state IDLE.
